// File: rtl/id_imm_stage_if.sv
// Bundle between the fetch side, the id_imm_stage pipeline register and the
// extend/decode consumers downstream.
// master: environment view (drives fetch word, flush, out_ready).
// slave: stage view (drives in_ready and the registered decode outputs).
interface id_imm_stage_if;
  // Upstream fetch handshake
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        flush;

  // Downstream handshake and registered fields
  logic        out_valid;
  logic        out_ready;
  logic [15:0] a;
  logic        sext;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  opcode;
  logic [31:0] pc_out;
  logic        uses_imm;
  logic        illegal;

  modport master (
    output in_valid, instr, pc_in, flush, out_ready,
    input  in_ready, out_valid, a, sext, rs, rt, rd, opcode, pc_out,
           uses_imm, illegal
  );

  modport slave (
    input  in_valid, instr, pc_in, flush, out_ready,
    output in_ready, out_valid, a, sext, rs, rt, rd, opcode, pc_out,
           uses_imm, illegal
  );
endinterface

// File: rtl/id_imm_stage.sv
// Decode-stage pipeline register feeding the immediate extender.
// Captures one fetched word with its PC, pre-decodes the sign-extension
// select, the immediate-operand flag and an illegal-opcode flag, and hands
// the word downstream under valid/ready flow control. A flush empties the
// stage and drops any word offered in the same cycle.
module id_imm_stage (
  input  logic               clk,
  input  logic               rst_n,
  id_imm_stage_if.slave      bus
);

  // Opcodes recognised by the decoder
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Held state
  logic        valid_q,    valid_d;
  logic [31:0] instr_q,    instr_d;
  logic [31:0] pc_q,       pc_d;
  logic        sext_q,     sext_d;
  logic        uses_imm_q, uses_imm_d;
  logic        illegal_q,  illegal_d;

  // Combinational decode of the incoming word
  logic        dec_sext;
  logic        dec_uses_imm;
  logic        dec_illegal;
  logic        load;

  // Stage can take a word when empty, when the held word leaves this cycle,
  // or when a flush is discarding the held word anyway.
  assign bus.in_ready = !valid_q || bus.out_ready || bus.flush;

  // A flush cycle never captures, even if the stage is otherwise ready.
  assign load = bus.in_valid && bus.in_ready && !bus.flush;

  // Opcode decode: immediate format and extension mode of the fetched word
  always_comb begin
    dec_sext     = 1'b0;
    dec_uses_imm = 1'b0;
    dec_illegal  = 1'b0;
    unique case (bus.instr[31:26])
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LW, OP_SW, OP_BEQ, OP_BNE: begin
        dec_sext     = 1'b1;
        dec_uses_imm = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec_uses_imm = 1'b1;
      end
      OP_RTYPE, OP_J, OP_JAL: begin
        // Legal, no immediate operand, zero-extend select
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Next-state: flush beats load, load beats drain; data only moves on load
  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    sext_d     = sext_q;
    uses_imm_d = uses_imm_q;
    illegal_d  = illegal_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = bus.instr;
      pc_d       = bus.pc_in;
      sext_d     = dec_sext;
      uses_imm_d = dec_uses_imm;
      illegal_d  = dec_illegal;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Pipeline register; reset clears word and flags without waiting for clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_q       <= '0;
      sext_q     <= 1'b0;
      uses_imm_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      sext_q     <= sext_d;
      uses_imm_q <= uses_imm_d;
      illegal_q  <= illegal_d;
    end
  end

  // Field outputs are raw slices of the captured word
  assign bus.out_valid = valid_q;
  assign bus.a         = instr_q[15:0];
  assign bus.rd        = instr_q[15:11];
  assign bus.rt        = instr_q[20:16];
  assign bus.rs        = instr_q[25:21];
  assign bus.opcode    = instr_q[31:26];
  assign bus.pc_out    = pc_q;
  assign bus.sext      = sext_q;
  assign bus.uses_imm  = uses_imm_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_id_imm_stage.sv
// Self-checking bench for id_imm_stage: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_id_imm_stage;

  logic clk;
  logic rst_n;
  id_imm_stage_if bus ();

  id_imm_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: whether a word is held, and the last captured word/PC
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;

  // Opcode classes as listed in the instruction set table
  logic [5:0] sext_ops [8] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h04, 6'h05};
  logic [5:0] zext_ops [7] = '{6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h00, 6'h02, 6'h03};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Classify an opcode by table membership
  function automatic void ref_decode(input logic [5:0] op, output bit sx, output bit ui, output bit il);
    bit in_s = 0;
    bit in_z = 0;
    foreach (sext_ops[i]) if (sext_ops[i] == op) in_s = 1;
    foreach (zext_ops[i]) if (zext_ops[i] == op) in_z = 1;
    sx = in_s;
    ui = in_s || (op >= 6'h0C && op <= 6'h0F);
    il = !(in_s || in_z);
  endfunction

  task automatic check_outputs(input string tag);
    bit sx, ui, il;
    ref_decode(m_instr[31:26], sx, ui, il);
    check_val({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    check_val({tag, ".in_ready"},  32'(bus.in_ready),
              32'(!m_valid || bus.out_ready || bus.flush));
    check_val({tag, ".a"},        32'(bus.a),        32'(m_instr[15:0]));
    check_val({tag, ".rs"},       32'(bus.rs),       32'(m_instr[25:21]));
    check_val({tag, ".rt"},       32'(bus.rt),       32'(m_instr[20:16]));
    check_val({tag, ".rd"},       32'(bus.rd),       32'(m_instr[15:11]));
    check_val({tag, ".opcode"},   32'(bus.opcode),   32'(m_instr[31:26]));
    check_val({tag, ".pc_out"},   bus.pc_out,        m_pc);
    check_val({tag, ".sext"},     32'(bus.sext),     32'(sx));
    check_val({tag, ".uses_imm"}, 32'(bus.uses_imm), 32'(ui));
    check_val({tag, ".illegal"},  32'(bus.illegal),  32'(il));
  endtask

  // Transaction-level update for the clock edge about to happen
  task automatic model_advance();
    bit accept;
    accept = bus.in_valid && !bus.flush && (!m_valid || bus.out_ready);
    if (bus.flush) begin
      m_valid = 0;
    end else if (accept) begin
      m_valid = 1;
      m_instr = bus.instr;
      m_pc    = bus.pc_in;
    end else if (bus.out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit fl, input bit ordy);
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.pc_in     = pc;
    bus.flush     = fl;
    bus.out_ready = ordy;
  endtask

  // One cycle: check at negedge, advance the model, land #1 after posedge
  task automatic step(input string tag);
    @(negedge clk);
    check_outputs(tag);
    $display("%s: in_valid=%0b instr=%08h flush=%0b out_ready=%0b in_ready=%0b out_valid=%0b a=%04h",
             tag, bus.in_valid, bus.instr, bus.flush, bus.out_ready,
             bus.in_ready, bus.out_valid, bus.a);
    model_advance();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  legal [15] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B, 6'h04, 6'h05,
                                6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h00, 6'h02, 6'h03};
    w = $urandom;
    if ($urandom_range(1, 0) == 1) w[31:26] = legal[$urandom_range(14, 0)];
    return w;
  endfunction

  initial begin
    m_valid = 0;
    m_instr = '0;
    m_pc    = '0;
    rst_n   = 1'b0;
    drive(0, 32'h0, 32'h0, 0, 0);

    // Reset state
    #3;
    check_outputs("reset");
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // addi: sign-extended immediate, one-cycle latency
    drive(1, 32'h2008AAAA, 32'h00400000, 0, 1);
    step("addi");
    check_val("addi.out_valid", 32'(bus.out_valid), 32'd1);
    check_val("addi.a",         32'(bus.a),         32'hAAAA);
    check_val("addi.sext",      32'(bus.sext),      32'd1);
    check_val("addi.rt",        32'(bus.rt),        32'd8);
    check_val("addi.uses_imm",  32'(bus.uses_imm),  32'd1);
    check_val("addi.pc_out",    bus.pc_out,         32'h00400000);

    // ori: zero-extended immediate
    drive(1, 32'h3508AAAA, 32'h00400004, 0, 1);
    step("ori");
    check_val("ori.a",        32'(bus.a),        32'hAAAA);
    check_val("ori.sext",     32'(bus.sext),     32'd0);
    check_val("ori.rs",       32'(bus.rs),       32'd8);
    check_val("ori.rt",       32'(bus.rt),       32'd8);
    check_val("ori.uses_imm", 32'(bus.uses_imm), 32'd1);
    check_val("ori.illegal",  32'(bus.illegal),  32'd0);

    // Backpressure for three cycles, then zero-bubble handoff
    drive(1, 32'h8C435555, 32'h00400008, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall");
      check_val("stall.in_ready", 32'(bus.in_ready), 32'd0);
      check_val("stall.a",        32'(bus.a),        32'hAAAA);
      check_val("stall.pc_out",   bus.pc_out,        32'h00400004);
    end
    bus.out_ready = 1;
    #1;
    check_val("handoff.in_ready", 32'(bus.in_ready), 32'd1);
    step("handoff");
    check_val("handoff.out_valid", 32'(bus.out_valid), 32'd1);
    check_val("handoff.a",         32'(bus.a),         32'h5555);
    check_val("handoff.opcode",    32'(bus.opcode),    32'h23);

    // Flush with a held word and a simultaneous incoming word
    drive(1, 32'h2108BBBB, 32'h0040000C, 1, 0);
    step("flush");
    check_val("flush.out_valid", 32'(bus.out_valid), 32'd0);
    check_val("flush.a",         32'(bus.a),         32'h5555);
    drive(0, 32'h0, 32'h0, 0, 0);
    step("post_flush");
    check_val("post_flush.out_valid", 32'(bus.out_valid), 32'd0);

    // Unrecognised opcode still passes through
    drive(1, 32'hFC000000, 32'h00400010, 0, 0);
    step("illegal");
    check_val("illegal.out_valid", 32'(bus.out_valid), 32'd1);
    check_val("illegal.illegal",   32'(bus.illegal),   32'd1);
    check_val("illegal.sext",      32'(bus.sext),      32'd0);
    check_val("illegal.uses_imm",  32'(bus.uses_imm),  32'd0);

    // Asynchronous reset between edges while a word is held
    rst_n = 1'b0;
    #2;
    m_valid = 0;
    m_instr = '0;
    m_pc    = '0;
    check_val("async_rst.out_valid", 32'(bus.out_valid), 32'd0);
    check_val("async_rst.opcode",    32'(bus.opcode),    32'd0);
    check_val("async_rst.pc_out",    bus.pc_out,         32'd0);
    check_val("async_rst.illegal",   32'(bus.illegal),   32'd0);
    check_val("async_rst.in_ready",  32'(bus.in_ready),  32'd1);
    #1;
    rst_n = 1'b1;

    // First edge after reset accepts normally
    drive(1, 32'h1485FFFE, 32'h00400014, 0, 0);
    step("post_rst");
    check_val("post_rst.out_valid", 32'(bus.out_valid), 32'd1);
    check_val("post_rst.a",         32'(bus.a),         32'hFFFE);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(9, 0) < 7, rand_instr(), $urandom,
            $urandom_range(12, 0) == 0, $urandom_range(9, 0) < 6);
      step($sformatf("rand%0d", n));
    end
    drive(0, 32'h0, 32'h0, 0, 1);
    step("drain");
    @(negedge clk);
    check_outputs("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_imm_stage.md
ID_IMM_STAGE -- requirements
Module: id_imm_stage

Purpose: decode-stage pipeline register upstream of extend; captures fetched instruction, supplies a (16-bit immediate) and sext to extend, plus register fields, with valid/ready flow control and flush.

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, upstream fetch word valid.
REQ-004 SHALL have port in_ready, output, 1, stage can accept this cycle.
REQ-005 SHALL have port instr, input, 32, fetched instruction word.
REQ-006 SHALL have port pc_in, input, 32, PC of instr.
REQ-007 SHALL have port flush, input, 1, discard held and incoming word.
REQ-008 SHALL have port out_valid, output, 1, registered word valid.
REQ-009 SHALL have port out_ready, input, 1, downstream consumes this cycle.
REQ-010 SHALL have ports a (output, 16, instr[15:0] to extend) and sext (output, 1, 1 = sign-extend, 0 = zero-extend).
REQ-011 SHALL have ports rs, rt, rd (output, 5 each, instr[25:21], [20:16], [15:11]).
REQ-012 SHALL have ports opcode (output, 6, instr[31:26]) and pc_out (output, 32, registered pc_in).
REQ-013 SHALL have ports uses_imm (output, 1, I-type immediate operand) and illegal (output, 1, unrecognised opcode).

Function
REQ-014 SHALL assert in_ready = !out_valid || out_ready || flush (combinational).
REQ-015 SHALL load all output registers from instr/pc_in and set out_valid = 1 when in_valid && in_ready && !flush.
REQ-016 SHALL clear out_valid when out_ready && out_valid and no new load occurs in that cycle.
REQ-017 SHALL hold all outputs unchanged while out_valid && !out_ready && !flush (backpressure).
REQ-018 SHALL, on flush, clear out_valid next cycle and drop any simultaneous input; flush has priority over load and over out_ready.
REQ-019 SHALL support back-to-back transfer: out_valid && out_ready && in_valid loads the new word in the same edge, out_valid stays 1, zero bubbles.
REQ-020 SHALL decode sext = 1 for opcodes 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne.
REQ-021 SHALL decode sext = 0 for 0x0C andi, 0x0D ori, 0x0E xori, 0x0F lui, 0x00 R-type, 0x02 j, 0x03 jal.
REQ-022 SHALL set uses_imm = 1 for all opcodes in REQ-020 and 0x0C-0x0F; 0 otherwise.
REQ-023 SHALL set illegal = 1, sext = 0, uses_imm = 0 for any opcode not listed in REQ-020/021; word still passes with out_valid.
REQ-024 SHALL register decode results (sext, uses_imm, illegal) with the word: latency in_valid-accept to out_valid = 1 cycle.
REQ-025 SHALL keep a, rs, rt, rd, opcode, pc_out as raw bit slices of the captured word, no modification.

Reset
REQ-026 SHALL, while rst_n = 0, force out_valid = 0 and all data outputs (a, sext, rs, rt, rd, opcode, pc_out, uses_imm, illegal) to 0 immediately, independent of clk.
REQ-027 SHALL, on reset mid-transfer, discard the held word; first edge after rst_n rises accepts new input normally.
REQ-028 SHALL drive in_ready = 1 during and after reset (out_valid = 0).

Verification
REQ-029 SHALL pass: instr 0x2008AAAA (addi), pc 0x00400000, out_ready 1 -> next cycle out_valid 1, a 0xAAAA, sext 1, rt 8, uses_imm 1, pc_out 0x00400000.
REQ-030 SHALL pass: instr 0x3508AAAA (ori) -> a 0xAAAA, sext 0, rs 8, rt 8, uses_imm 1, illegal 0.
REQ-031 SHALL pass: word loaded, out_ready 0 for 3 cycles, new instr presented -> in_ready 0, outputs held; out_ready 1 -> new word loads same edge, no bubble.
REQ-032 SHALL pass: flush with in_valid 1 and held word valid -> next cycle out_valid 0, incoming word not captured.
REQ-033 SHALL pass: opcode 0x3F (instr 0xFC000000) -> out_valid 1, illegal 1, sext 0, uses_imm 0.
REQ-034 SHALL pass: rst_n low between clock edges with out_valid 1 -> out_valid and all outputs 0 before next edge.
